// File: rtl/exu_muldiv_ysyx_23060136_if.sv
// Request/response bundle between the EXU issue logic and the iterative
// RV32M unit. The master drives requests and out_ready; the unit is the slave.
interface exu_muldiv_ysyx_23060136_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/exu_muldiv_ysyx_23060136.sv
// Iterative RV32M multiply/divide unit: radix-2, one step per clock.
// Multiply is shift-add over a 2*XLEN accumulator, divide is restoring
// shift-subtract; both work on magnitudes and fix the sign on the last step.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed
// overflow and multiply-by-zero finish straight from IDLE with latency 1.
module exu_muldiv_ysyx_23060136 #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic busy,
    exu_muldiv_ysyx_23060136_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [XLEN-1:0]    a_q;        // |rs2|: multiplicand or divisor
    logic [2*XLEN-1:0]  acc;        // hi: partial product / remainder, lo: |rs1| / quotient
    logic               neg1, neg2; // effective operand signs
    logic               bzero;
    logic [XLEN-1:0]    result_q;
    logic [TAG_W-1:0]   otag_q;

    // ---------------- request decode ----------------
    logic            in_div, sgn1, sgn2, n1, n2, accept, early;
    logic [XLEN-1:0] m1, m2, early_res;

    assign in_div = bus.in_op[2];
    assign sgn1   = in_div ? !bus.in_op[0] : (bus.in_op == 3'd1 || bus.in_op == 3'd2);
    assign sgn2   = in_div ? !bus.in_op[0] : (bus.in_op == 3'd1);
    assign n1     = sgn1 & bus.in_rs1[XLEN-1];
    assign n2     = sgn2 & bus.in_rs2[XLEN-1];
    assign m1     = n1 ? -bus.in_rs1 : bus.in_rs1;
    assign m2     = n2 ? -bus.in_rs2 : bus.in_rs2;
    assign accept = bus.in_valid & (state == IDLE) & !flush;

`ifdef MULDIV_EARLY_OUT_EN
    logic zero1, zero2, ovf;
    assign zero1 = (bus.in_rs1 == '0);
    assign zero2 = (bus.in_rs2 == '0);
    assign ovf   = in_div & !bus.in_op[0]
                 & (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.in_rs2);
    assign early = in_div ? (zero2 | ovf) : (zero1 | zero2);

    // Special results: x/0 -> q=-1, r=x; overflow -> q=rs1, r=0; mul by 0 -> 0
    always_comb begin
        early_res = '0;
        if (in_div) begin
            if (zero2) early_res = bus.in_op[1] ? bus.in_rs1 : '1;
            else       early_res = bus.in_op[1] ? '0 : bus.in_rs1;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // ---------------- one iteration ----------------
    logic [XLEN-1:0]   hi, lo, quot, remv, q_mag, r_mag, final_res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] acc_step, prod_s;

    assign hi       = acc[2*XLEN-1:XLEN];
    assign lo       = acc[XLEN-1:0];
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, a_q};

    // Step: shift-add for multiply, restore-on-borrow for divide
    always_comb begin
        acc_step = {mul_sum, lo[XLEN-1:1]};
        if (op_q[2]) begin
            if (div_diff[XLEN]) acc_step = {div_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
            else                acc_step = {div_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction of the completed step; divisor 0 forces an all-ones quotient
    assign prod_s = (neg1 ^ neg2) ? -acc_step : acc_step;
    assign q_mag  = acc_step[XLEN-1:0];
    assign r_mag  = acc_step[2*XLEN-1:XLEN];
    assign quot   = bzero ? '1 : ((neg1 ^ neg2) ? -q_mag : q_mag);
    assign remv   = neg1 ? -r_mag : r_mag;

    // Select the architectural result for the latched op
    always_comb begin
        final_res = remv;
        case (op_q)
            3'd0:             final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = quot;
            default:          final_res = remv;
        endcase
    end

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; flush wins over everything including a pending result
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = early ? DONE : BUSY;
            BUSY: if (cnt == CNT_W'(XLEN-1)) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath: latch operands on accept, iterate in BUSY, publish on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            a_q      <= '0;
            acc      <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            bzero    <= 1'b0;
            result_q <= '0;
            otag_q   <= '0;
        end else if (!flush) begin
            if (accept) begin
                cnt   <= '0;
                op_q  <= bus.in_op;
                tag_q <= bus.in_tag;
                a_q   <= m2;
                acc   <= {{XLEN{1'b0}}, m1};
                neg1  <= n1;
                neg2  <= n2;
                bzero <= (bus.in_rs2 == '0);
                if (early) begin
                    result_q <= early_res;
                    otag_q   <= bus.in_tag;
                end
            end else if (state == BUSY) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(XLEN-1)) begin
                    result_q <= final_res;
                    otag_q   <= tag_q;
                end
            end
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = result_q;
    assign bus.out_tag    = otag_q;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_exu_muldiv_ysyx_23060136.sv
// Scoreboard bench for the iterative mul/div unit: the driver pushes the
// hand-computed result, tag and latency; a monitor pops on each handshake.
module tb_exu_muldiv_ysyx_23060136;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst, flush, busy;

    exu_muldiv_ysyx_23060136_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

    exu_muldiv_ysyx_23060136 #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    exp_t sbq[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Edges from accept edge to first out_valid sample: 32, or 0 (next cycle) on early-out
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        int early_lat;
        special = op[2] ? (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                        : (a == 0 || b == 0);
`ifdef MULDIV_EARLY_OUT_EN
        early_lat = 0;
`else
        early_lat = 32;
`endif
        return special ? early_lat : 32;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input bit push);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout: in_ready=%0b expected 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = tag;
        if (push) sbq.push_back('{res: res, tag: tag, acc: cyc + 1, lat: exp_lat(op, a, b)});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || busy) begin
            checks++; failures++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sbq.size());
        end
    endtask

    // Monitor: compare on each handshake; latency measured to the first valid cycle
    initial begin
        bit   seen;
        int   vcyc;
        exp_t e;
        seen = 1'b0;
        vcyc = 0;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    vcyc = cyc;
                end
                if (bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_result: got 0x%0h expected none", bus.out_result);
                    end else begin
                        e = sbq.pop_front();
                        chk("result",  bus.out_result, e.res);
                        chk("tag",     bus.out_tag, e.tag);
                        chk("latency", 64'(vcyc - e.acc), 64'(e.lat));
                    end
                    seen = 1'b0;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    vec_t vt[16] = '{
        '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003},
        '{3'd4, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234},
        '{3'd6, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234},
        '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd0, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000},
        '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001},
        '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF}
    };

    initial begin
        int n;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  bus.out_valid, 0);
        chk("rst_in_ready",   bus.in_ready, 1);
        chk("rst_busy",       busy, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_tag",    bus.out_tag, 0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, 5'(i + 1), vt[i].res, 1'b1);
            wait_drain();
        end

        // Backpressure: hold the result for 10 cycles
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue(3'd5, 32'd7, 32'd2, 5'h1A, 32'd3, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", bus.out_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid",  bus.out_valid, 1);
            chk("bp_out_result", bus.out_result, 32'd3);
            chk("bp_out_tag",    bus.out_tag, 5'h1A);
            chk("bp_in_ready",   bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready",  bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);

        // Flush at step 15, then a fresh request the following cycle
        issue(3'd0, 32'd5, 32'd7, 5'd3, 32'd35, 1'b0);
        repeat (16) @(negedge clk);
        chk("flush_pre_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy",      busy, 0);
        chk("flush_in_ready",  bus.in_ready, 1);
        chk("flush_out_valid", bus.out_valid, 0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b1);
        chk("post_flush_accept", busy, 1);
        wait_drain();

        // Flush together with in_valid in IDLE: not accepted
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd5;
        bus.in_rs1   = 32'd9;
        bus.in_rs2   = 32'd3;
        bus.in_tag   = 5'd7;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        chk("flush_idle_busy",     busy, 0);
        chk("flush_idle_in_ready", bus.in_ready, 1);
        repeat (3) @(negedge clk);
        chk("flush_idle_no_valid", bus.out_valid, 0);

        // Asynchronous reset mid-BUSY
        issue(3'd7, 32'd100, 32'd7, 5'd9, 32'd2, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid",  bus.out_valid, 0);
        chk("arst_in_ready",   bus.in_ready, 1);
        chk("arst_busy",       busy, 0);
        chk("arst_out_result", bus.out_result, 0);
        chk("arst_out_tag",    bus.out_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 1'b1);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
